// File: rtl/ibex_ex_wb_result_buffer_if.sv
// EX-to-writeback result buffer bus: EX push side, WB pop side and ID forwarding lookup.
interface ibex_ex_wb_result_buffer_if;
  logic             ex_valid_i;
  logic [31:0]      ex_result_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_rf_we_i;
  logic             ex_ready_o;

  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [4:0]       wb_rd_addr_o;
  logic [31:0]      wb_rf_wdata_o;
  logic             wb_rf_we_o;

  logic [1:0][4:0]  fwd_rs_addr_i;
  logic [1:0]       fwd_hit_o;
  logic [1:0][31:0] fwd_data_o;

  // Buffer side
  modport slave (
    input  ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rf_we_i, wb_ready_i, fwd_rs_addr_i,
    output ex_ready_o, wb_valid_o, wb_rd_addr_o, wb_rf_wdata_o, wb_rf_we_o, fwd_hit_o, fwd_data_o
  );

  // Pipeline side (EX producer, WB consumer, ID lookup)
  modport master (
    output ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rf_we_i, wb_ready_i, fwd_rs_addr_i,
    input  ex_ready_o, wb_valid_o, wb_rd_addr_o, wb_rf_wdata_o, wb_rf_we_o, fwd_hit_o, fwd_data_o
  );
endinterface

// File: rtl/ibex_ex_wb_result_buffer.sv
// In-order result FIFO between EX and writeback with youngest-entry forwarding to ID.
module ibex_ex_wb_result_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter bit          FwdEn = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  ibex_ex_wb_result_buffer_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_wb_valid;
  entry_t          r_wb;

  logic            w_ex_ready;
  logic            w_push;
  logic            w_pop;
  entry_t          w_new;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_remaining;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [1:0]      w_fwd_hit;
  logic [1:0][31:0] w_fwd_data;
  logic [PW-1:0]   w_fwd_idx;

  // Handshakes; readiness never looks at wb_ready_i so EX timing stays independent of WB
  always_comb begin
    w_ex_ready   = (r_count != CW'(DEPTH)) & ~flush_i;
    w_push       = bus.ex_valid_i & w_ex_ready;
    w_pop        = r_wb_valid & bus.wb_ready_i;
    w_new.rd     = bus.ex_rd_addr_i;
    w_new.data   = bus.ex_result_i;
    w_new.we     = bus.ex_rf_we_i & (bus.ex_rd_addr_i != 5'd0);
    w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    w_remaining  = r_count - CW'(w_pop);
    w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  end

  // Pointers, occupancy, storage and the registered head-of-queue view
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wb_valid <= 1'b0;
      r_wb       <= '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        r_mem[j] <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_wb_valid <= (w_count_nxt != '0);
      // Head stays put while stalled; an empty buffer keeps showing the last head
      if (w_remaining != '0) begin
        r_wb <= r_mem[w_rd_ptr_nxt];
      end else if (w_push) begin
        r_wb <= w_new;
      end
    end
  end

  // Forwarding lookup, oldest to youngest so the youngest match wins
  always_comb begin
    w_fwd_hit  = '0;
    w_fwd_data = '0;
    w_fwd_idx  = '0;
    if (FwdEn) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < int'(DEPTH); k++) begin
          w_fwd_idx = r_rd_ptr + PW'(k);
          if ((CW'(k) < r_count) && r_mem[w_fwd_idx].we &&
              (r_mem[w_fwd_idx].rd != 5'd0) &&
              (r_mem[w_fwd_idx].rd == bus.fwd_rs_addr_i[i])) begin
            w_fwd_hit[i]  = 1'b1;
            w_fwd_data[i] = r_mem[w_fwd_idx].data;
          end
        end
      end
    end
  end

  // Output drive
  assign count_o           = r_count;
  assign bus.ex_ready_o    = w_ex_ready;
  assign bus.wb_valid_o    = r_wb_valid;
  assign bus.wb_rd_addr_o  = r_wb.rd;
  assign bus.wb_rf_wdata_o = r_wb.data;
  assign bus.wb_rf_we_o    = r_wb.we;
  assign bus.fwd_hit_o     = w_fwd_hit;
  assign bus.fwd_data_o    = w_fwd_data;

  // Structural invariants
  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_count == CW'(DEPTH)) |-> !w_push);
  a_count_bound  : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= CW'(DEPTH));
  a_wb_stable    : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $past(r_wb_valid & ~bus.wb_ready_i & ~flush_i) |->
      (r_wb_valid && (r_wb == $past(r_wb))));

endmodule

// File: tb/tb_ibex_ex_wb_result_buffer.sv
// Directed self-checking bench for the EX/WB result buffer (DEPTH=2).
module tb_ibex_ex_wb_result_buffer;
  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] count;
  int         checks;
  int         errors;

  ibex_ex_wb_result_buffer_if bus ();

  ibex_ex_wb_result_buffer #(.DEPTH(2), .FwdEn(1'b1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .count_o (count),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic we);
    bus.ex_valid_i   = v;
    bus.ex_rd_addr_i = rd;
    bus.ex_result_i  = d;
    bus.ex_rf_we_i   = we;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    bus.wb_ready_i    = 1'b0;
    bus.fwd_rs_addr_i = '0;
    #12;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid_o); end
    checks++; if (bus.wb_rd_addr_o !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d want 0", bus.wb_rd_addr_o); end
    checks++; if (bus.wb_rf_wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", bus.wb_rf_wdata_o); end
    checks++; if (bus.wb_rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b want 0", bus.wb_rf_we_o); end
    checks++; if (bus.fwd_hit_o !== 2'b00) begin errors++; $display("FAIL reset_fwd_hit: got %b want 00", bus.fwd_hit_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.ex_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b want 1", bus.ex_ready_o); end
  endtask

  task automatic test_single_push();
    bus.wb_ready_i = 1'b1;
    drive_ex(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    tick();
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checks++; if (bus.wb_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.wb_valid_o); end
    checks++; if (bus.wb_rd_addr_o !== 5'd5) begin errors++; $display("FAIL single_rd: got %0d want 5", bus.wb_rd_addr_o); end
    checks++; if (bus.wb_rf_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", bus.wb_rf_wdata_o); end
    checks++; if (bus.wb_rf_we_o !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", bus.wb_rf_we_o); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", count); end
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_empty_valid: got %b want 0", bus.wb_valid_o); end
    checks++; if (bus.wb_rf_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_empty_hold: got %h want deadbeef", bus.wb_rf_wdata_o); end
  endtask

  task automatic test_back_pressure();
    bus.wb_ready_i = 1'b0;
    drive_ex(1'b1, 5'd1, 32'h11, 1'b1);
    tick();
    drive_ex(1'b1, 5'd2, 32'h22, 1'b1);
    tick();
    drive_ex(1'b1, 5'd3, 32'h33, 1'b1);
    #1;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_count_full: got %0d want 2", count); end
    checks++; if (bus.ex_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ex_ready: got %b want 0", bus.ex_ready_o); end
    tick();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_count_hold: got %0d want 2", count); end
    checks++; if (bus.wb_rf_wdata_o !== 32'h11 || bus.wb_rd_addr_o !== 5'd1) begin errors++; $display("FAIL bp_head_hold: got rd %0d data %h want rd 1 data 11", bus.wb_rd_addr_o, bus.wb_rf_wdata_o); end
    bus.wb_ready_i = 1'b1;
    #1;
    checks++; if (bus.ex_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_indep: got %b want 0", bus.ex_ready_o); end
    tick();
    checks++; if (count !== 2'd1 || bus.wb_rf_wdata_o !== 32'h22) begin errors++; $display("FAIL bp_drain1: got count %0d data %h want 1 22", count, bus.wb_rf_wdata_o); end
    checks++; if (bus.ex_ready_o !== 1'b1) begin errors++; $display("FAIL bp_slot_free: got %b want 1", bus.ex_ready_o); end
    tick();
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checks++; if (count !== 2'd1 || bus.wb_rf_wdata_o !== 32'h33 || bus.wb_rd_addr_o !== 5'd3) begin errors++; $display("FAIL bp_drain2: got count %0d rd %0d data %h want 1 3 33", count, bus.wb_rd_addr_o, bus.wb_rf_wdata_o); end
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL bp_empty: got %0d want 0", count); end
  endtask

  task automatic test_full_simul();
    bus.wb_ready_i = 1'b0;
    drive_ex(1'b1, 5'd10, 32'hA0, 1'b1);
    tick();
    drive_ex(1'b1, 5'd11, 32'hA1, 1'b1);
    tick();
    bus.wb_ready_i = 1'b1;
    drive_ex(1'b1, 5'd12, 32'hA2, 1'b1);
    #1;
    checks++; if (bus.ex_ready_o !== 1'b0) begin errors++; $display("FAIL full_refuse: got %b want 0", bus.ex_ready_o); end
    tick();
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL full_count_2to1: got %0d want 1", count); end
    checks++; if (bus.ex_ready_o !== 1'b1) begin errors++; $display("FAIL full_accept_next: got %b want 1", bus.ex_ready_o); end
    tick();
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    bus.wb_ready_i = 1'b0;
    #1;
    checks++; if (count !== 2'd1 || bus.wb_rf_wdata_o !== 32'hA2) begin errors++; $display("FAIL full_pushed: got count %0d data %h want 1 a2", count, bus.wb_rf_wdata_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
  endtask

  task automatic test_forwarding();
    bus.wb_ready_i    = 1'b0;
    bus.fwd_rs_addr_i = {5'd7, 5'd7};
    drive_ex(1'b1, 5'd7, 32'd1, 1'b1);
    #1;
    checks++; if (bus.fwd_hit_o !== 2'b00) begin errors++; $display("FAIL fwd_same_cycle: got %b want 00", bus.fwd_hit_o); end
    tick();
    drive_ex(1'b1, 5'd7, 32'd2, 1'b1);
    #1;
    checks++; if (bus.fwd_hit_o !== 2'b11 || bus.fwd_data_o[0] !== 32'd1) begin errors++; $display("FAIL fwd_one_entry: got hit %b data %h want 11 1", bus.fwd_hit_o, bus.fwd_data_o[0]); end
    tick();
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    bus.fwd_rs_addr_i = {5'd0, 5'd7};
    #1;
    checks++; if (bus.fwd_hit_o !== 2'b01) begin errors++; $display("FAIL fwd_hit: got %b want 01", bus.fwd_hit_o); end
    checks++; if (bus.fwd_data_o[0] !== 32'd2) begin errors++; $display("FAIL fwd_youngest: got %h want 2", bus.fwd_data_o[0]); end
    bus.wb_ready_i = 1'b1;
    tick();
    checks++; if (bus.fwd_hit_o[0] !== 1'b1 || bus.fwd_data_o[0] !== 32'd2) begin errors++; $display("FAIL fwd_after_pop: got hit %b data %h want 1 2", bus.fwd_hit_o[0], bus.fwd_data_o[0]); end
    tick();
    checks++; if (count !== 2'd0 || bus.fwd_hit_o !== 2'b00) begin errors++; $display("FAIL fwd_drained: got count %0d hit %b want 0 00", count, bus.fwd_hit_o); end
    bus.wb_ready_i = 1'b0;
  endtask

  task automatic test_reg_zero();
    bus.wb_ready_i    = 1'b0;
    bus.fwd_rs_addr_i = '0;
    drive_ex(1'b1, 5'd0, 32'h1234, 1'b1);
    tick();
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checks++; if (bus.wb_valid_o !== 1'b1 || bus.wb_rf_wdata_o !== 32'h1234) begin errors++; $display("FAIL x0_stored: got valid %b data %h want 1 1234", bus.wb_valid_o, bus.wb_rf_wdata_o); end
    checks++; if (bus.wb_rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_we: got %b want 0", bus.wb_rf_we_o); end
    checks++; if (bus.fwd_hit_o !== 2'b00) begin errors++; $display("FAIL x0_fwd: got %b want 00", bus.fwd_hit_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL x0_popped: got %0d want 0", count); end
    bus.wb_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    bus.wb_ready_i = 1'b0;
    drive_ex(1'b1, 5'd4, 32'h44, 1'b1);
    tick();
    drive_ex(1'b1, 5'd6, 32'h66, 1'b1);
    tick();
    drive_ex(1'b1, 5'd8, 32'h88, 1'b1);
    bus.wb_ready_i = 1'b1;
    flush          = 1'b1;
    #1;
    checks++; if (bus.ex_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", bus.ex_ready_o); end
    tick();
    flush = 1'b0;
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    bus.wb_ready_i    = 1'b0;
    bus.fwd_rs_addr_i = {5'd8, 5'd4};
    #1;
    checks++; if (count !== 2'd0 || bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_clear: got count %0d valid %b want 0 0", count, bus.wb_valid_o); end
    checks++; if (bus.fwd_hit_o !== 2'b00) begin errors++; $display("FAIL flush_fwd: got %b want 00", bus.fwd_hit_o); end
    tick();
    checks++; if (count !== 2'd0 || bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_push: got count %0d valid %b want 0 0", count, bus.wb_valid_o); end
  endtask

  task automatic test_async_reset();
    bus.wb_ready_i    = 1'b0;
    bus.fwd_rs_addr_i = {5'd9, 5'd9};
    drive_ex(1'b1, 5'd9, 32'h99, 1'b1);
    tick();
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 2'd0 || bus.wb_valid_o !== 1'b0 || bus.fwd_hit_o !== 2'b00) begin errors++; $display("FAIL async_reset: got count %0d valid %b hit %b want 0 0 00", count, bus.wb_valid_o, bus.fwd_hit_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back_wrap();
    int  sent;
    int  rcv;
    logic do_push;
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      drive_ex(sent < 10, 5'(sent + 1), 32'(sent), 1'b1);
      bus.wb_ready_i = 1'($urandom_range(0, 1));
      #1;
      do_push = bus.ex_valid_i & bus.ex_ready_o;
      if (bus.wb_valid_o && bus.wb_ready_i) begin
        checks++;
        if (bus.wb_rf_wdata_o !== 32'(rcv)) begin errors++; $display("FAIL wrap_order: got %0d want %0d", bus.wb_rf_wdata_o, rcv); end
        rcv++;
      end
      if (do_push) sent++;
      tick();
    end
    drive_ex(1'b0, 5'd0, 32'd0, 1'b0);
    bus.wb_ready_i = 1'b0;
    #1;
    checks++; if (rcv != 10) begin errors++; $display("FAIL wrap_timeout: got %0d pops want 10", rcv); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL wrap_residue: got count %0d want 0", count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_push();
    test_back_pressure();
    test_full_simul();
    test_forwarding();
    test_reg_zero();
    test_flush();
    test_async_reset();
    test_back_to_back_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
